// File: rtl/coef_pkg.sv
// Shared constants and FSM encoding for the coefficient loader.
// Imported by the loader top and its RAM.
package coef_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int WORD_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LO,
    S_HI,
    S_CHK
  } state_t;

endpackage

// File: rtl/coef_ram.sv
// Simple dual-port coefficient bank.
// One write port, registered read-first read port.
module coef_ram
  import coef_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/coef_loader.sv
// Framed byte-stream coefficient loader: validates SYNC/LEN/CHK framing
// and commits 16-bit words into the on-chip bank.
module coef_loader
  import coef_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              loaded,
  output logic [ADDR_W:0]   word_count,
  output logic              frame_err
);

  localparam logic [8:0] LEN_MAX = 9'(DEPTH);

  state_t            state;
  logic              rdy;
  logic              take;
  logic [7:0]        len;
  logic [7:0]        acc;
  logic [7:0]        lo;
  logic [ADDR_W:0]   widx;
  logic [ADDR_W:0]   widx_n;
  logic              we;
  logic [WORD_W-1:0] ram_q;
  logic              rd_ok;

  assign s_ready = rdy;
  assign take    = s_valid && rdy;
  assign widx_n  = widx + 1'b1;
  assign we      = take && (state == S_HI);

  coef_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (widx[ADDR_W-1:0]),
    .wdata (WORD_W'({s_data, lo})),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Range flag is registered alongside the RAM read so the clamp lines up.
  assign rd_data = rd_ok ? ram_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rdy        <= 1'b0;
      loaded     <= 1'b0;
      word_count <= '0;
      frame_err  <= 1'b0;
      len        <= '0;
      acc        <= '0;
      lo         <= '0;
      widx       <= '0;
      rd_ok      <= 1'b0;
    end else begin
      rdy       <= 1'b1;
      frame_err <= 1'b0;
      rd_ok     <= {1'b0, rd_addr} < word_count;
      if (take) begin
        unique case (state)
          S_IDLE: begin
            if (s_data == SYNC_BYTE) begin
              loaded <= 1'b0;
              state  <= S_LEN;
            end
          end
          S_LEN: begin
            if (s_data == 8'd0 || {1'b0, s_data} > LEN_MAX) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end else begin
              len   <= s_data;
              acc   <= s_data;
              widx  <= '0;
              state <= S_LO;
            end
          end
          S_LO: begin
            lo    <= s_data;
            acc   <= acc ^ s_data;
            state <= S_HI;
          end
          S_HI: begin
            acc   <= acc ^ s_data;
            widx  <= widx_n;
            state <= (8'(widx_n) == len) ? S_CHK : S_LO;
          end
          S_CHK: begin
            if (s_data == acc) begin
              loaded     <= 1'b1;
              word_count <= widx;
            end else begin
              frame_err <= 1'b1;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coef_loader.sv
// Scoreboard bench for coef_loader: frame outcomes and read words
// are queued at stimulus time and popped when the DUT responds.
module tb_coef_loader;
  import coef_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        loaded;
  logic [6:0]  word_count;
  logic        frame_err;

  coef_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .loaded     (loaded),
    .word_count (word_count),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [6:0] wc;
  } evt_t;

  evt_t        evq [$];
  logic [15:0] rdq [$];
  logic [15:0] wq [$];
  logic [15:0] exp_mem [64];
  int          cur_wc;
  int          n_run;
  int          n_fail;
  logic        ld_q;
  logic        fe_q;
  evt_t        ev;

  int fc [10] = '{-48, 1081, -146, -256, -109, 976, 31, 466, -905, 33};
  int fb [10] = '{46, -9, -127, 70, -23, -93, -20, -88, -86, -843};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame outcome monitor: commit rise or error pulse pops the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err || (loaded && !ld_q)) begin
        if (evq.size() == 0) begin
          check("unexp_evt", 1, 0);
        end else begin
          ev = evq.pop_front();
          check("evt_err", frame_err, ev.err);
          check("evt_wc", word_count, ev.wc);
        end
      end
      if (frame_err && fe_q) check("ferr_1cyc", 1, 0);
    end
    ld_q = loaded;
    fe_q = frame_err;
  end

  task automatic put(input logic [7:0] b, input int gap);
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_addr = a[5:0];
    rdq.push_back((a < cur_wc) ? exp_mem[a] : 16'h0);
    @(negedge clk);
    check($sformatf("rd%0d", a), rd_data, rdq.pop_front());
  endtask

  task automatic load_words(input int src [10]);
    wq.delete();
    for (int i = 0; i < 10; i++) wq.push_back(16'(src[i]));
  endtask

  task automatic send_frame(input logic bad, input int gmax);
    logic [7:0]  c;
    logic [15:0] w;
    put(SYNC_BYTE, $urandom_range(gmax, 0));
    check("sync_clr", loaded, 0);
    c = 8'(wq.size());
    put(c, $urandom_range(gmax, 0));
    foreach (wq[i]) begin
      w = wq[i];
      exp_mem[i] = w;
      c = c ^ w[7:0] ^ w[15:8];
      put(w[7:0], $urandom_range(gmax, 0));
      put(w[15:8], $urandom_range(gmax, 0));
    end
    if (bad) c = c ^ 8'h01;
    evq.push_back('{err: bad, wc: bad ? 7'(cur_wc) : 7'(wq.size())});
    if (!bad) cur_wc = wq.size();
    put(c, $urandom_range(gmax, 0));
    check("frm_loaded", loaded, !bad);
    repeat (2) @(negedge clk);
    check("evq_empty", evq.size(), 0);
  endtask

  task automatic bad_len(input logic [7:0] l);
    put(SYNC_BYTE, 0);
    evq.push_back('{err: 1'b1, wc: 7'(cur_wc)});
    put(l, 0);
    put(8'h12, 0);
    put(8'h34, 0);
    check("blen_evq", evq.size(), 0);
    check("blen_loaded", loaded, 0);
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    cur_wc  = 0;
    ld_q    = 1'b0;
    fe_q    = 1'b0;
    s_data  = 8'h0;
    s_valid = 1'b0;
    rd_addr = 6'd0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", s_ready, 0);
    check("rst_loaded", loaded, 0);
    check("rst_wc", word_count, 0);
    check("rst_rd", rd_data, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_up", s_ready, 1);

    load_words(fc);
    send_frame(1'b0, 0);
    check("fc_wc", word_count, 10);
    for (int i = 0; i <= 10; i++) rd(i);

    load_words(fb);
    send_frame(1'b0, 0);
    rd(9);
    check("fb_w9", rd_data, 16'hFCB5);
    rd(2);
    check("fb_w2", rd_data, 16'hFF81);

    load_words(fc);
    send_frame(1'b1, 0);
    check("bchk_wc", word_count, 10);
    rd(0);

    bad_len(8'h00);
    bad_len(8'h41);

    put(8'h00, 0);
    put(8'hFF, 1);
    put(8'h5A, 0);
    load_words(fc);
    send_frame(1'b0, 3);
    check("noise_wc", word_count, 10);
    for (int i = 0; i <= 10; i++) rd(i);

    put(SYNC_BYTE, 0);
    put(8'h0A, 0);
    for (int i = 0; i < 5; i++) put(8'(i + 1), 0);
    rst = 1'b1;
    evq.delete();
    cur_wc = 0;
    @(negedge clk);
    check("mrst_ready", s_ready, 0);
    check("mrst_loaded", loaded, 0);
    check("mrst_wc", word_count, 0);
    check("mrst_ferr", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_rd", rd_data, 0);
    load_words(fc);
    send_frame(1'b0, 0);
    check("mrst_fwc", word_count, 10);
    for (int i = 0; i < 10; i++) rd(i);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
